// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA rectangle renderer.
package vga_pkg;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int COORD_W_D  = 11;
  localparam int BLINK_BIT  = 5;
endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider, h/v raster counters, raw active-low syncs, visible flag
// and last-pixel-of-frame strobe.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int COORD_W  = COORD_W_D
) (
  input  logic               CLOCK_50,
  input  logic               nReset,
  output logic               pix_en,
  output logic [COORD_W-1:0] h_cnt,
  output logic [COORD_W-1:0] v_cnt,
  output logic               hs_raw,
  output logic               vs_raw,
  output logic               visible,
  output logic               frame_end
);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_ACTIVE);

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      pix_en <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign hs_raw    = !(h_cnt >= HS_START && h_cnt <= HS_END);
  assign vs_raw    = !(v_cnt >= VS_START && v_cnt <= VS_END);
  assign visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
endmodule

// File: rtl/vga_rect_engine.sv
// VGA timing plus N prioritised rectangle overlay with per-frame shadowed inputs.
// Optional blink support is built when RECT_BLINK_EN is defined.
module vga_rect_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int N_RECT   = 4,
  parameter int COORD_W  = COORD_W_D
) (
  input  logic                      CLOCK_50,
  input  logic                      nReset,
  input  logic [N_RECT*COORD_W-1:0] rect_x0,
  input  logic [N_RECT*COORD_W-1:0] rect_x1,
  input  logic [N_RECT*COORD_W-1:0] rect_y0,
  input  logic [N_RECT*COORD_W-1:0] rect_y1,
  input  logic [N_RECT*24-1:0]      rect_color,
  input  logic [N_RECT-1:0]         rect_en,
  input  logic [N_RECT-1:0]         rect_blink,
  input  logic [23:0]               bg_color,
  output logic [7:0]                VGA_R,
  output logic [7:0]                VGA_G,
  output logic [7:0]                VGA_B,
  output logic                      VGA_HS,
  output logic                      VGA_VS,
  output logic                      VGA_CLK,
  output logic                      VGA_BLANK_N,
  output logic                      frame_start
);
  logic               pix_en, hs_raw, vs_raw, visible, frame_end;
  logic [COORD_W-1:0] h_cnt, v_cnt;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .COORD_W(COORD_W)
  ) u_timing (
    .CLOCK_50(CLOCK_50), .nReset(nReset), .pix_en(pix_en),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .hs_raw(hs_raw), .vs_raw(vs_raw),
    .visible(visible), .frame_end(frame_end)
  );

  logic [N_RECT-1:0][COORD_W-1:0] sx0, sx1, sy0, sy1;
  rgb_t [N_RECT-1:0]              scol;
  rgb_t                           sbg;
  logic [N_RECT-1:0]              sen, en_eff;
  logic                           loaded, load;

  // The very first pixel cycle after reset also loads, so a frame never renders stale zeros
  assign load        = pix_en && (frame_end || !loaded);
  assign frame_start = load;
  assign VGA_CLK     = pix_en;

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      loaded <= 1'b0;
      sx0 <= '0; sx1 <= '0; sy0 <= '0; sy1 <= '0;
      scol <= '0; sbg <= '0; sen <= '0;
    end else if (load) begin
      loaded <= 1'b1;
      sx0 <= rect_x0; sx1 <= rect_x1; sy0 <= rect_y0; sy1 <= rect_y1;
      scol <= rect_color; sbg <= bg_color; sen <= rect_en;
    end
  end

`ifdef RECT_BLINK_EN
  logic [BLINK_BIT:0] frame_cnt;
  logic [N_RECT-1:0]  sblink;
  logic               blink_off;

  // Blink phase is shadowed with the rest, using the count of frames already started
  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      frame_cnt <= '0;
      sblink    <= '0;
      blink_off <= 1'b0;
    end else if (load) begin
      frame_cnt <= frame_cnt + 1'b1;
      sblink    <= rect_blink;
      blink_off <= frame_cnt[BLINK_BIT];
    end
  end
  assign en_eff = sen & ~(sblink & {N_RECT{blink_off}});
`else
  logic unused_blink;
  assign unused_blink = ^rect_blink;
  assign en_eff = sen;
`endif

  logic [N_RECT-1:0] hit_c, hit_q;
  logic              vis_q, hs_q, vs_q;
  rgb_t              pix_c, pix_q;

  for (genvar i = 0; i < N_RECT; i++) begin : g_hit
    assign hit_c[i] = en_eff[i] && (h_cnt >= sx0[i]) && (h_cnt <= sx1[i])
                                && (v_cnt >= sy0[i]) && (v_cnt <= sy1[i]);
  end

  // Lowest index wins: scan from the top so lower indices overwrite
  always_comb begin
    pix_c = sbg;
    for (int i = N_RECT - 1; i >= 0; i--)
      if (hit_q[i]) pix_c = scol[i];
    if (!vis_q) pix_c = '0;
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      hit_q       <= '0;
      vis_q       <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      pix_q       <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
    end else if (pix_en) begin
      hit_q       <= hit_c;
      vis_q       <= visible;
      hs_q        <= hs_raw;
      vs_q        <= vs_raw;
      pix_q       <= pix_c;
      VGA_HS      <= hs_q;
      VGA_VS      <= vs_q;
      VGA_BLANK_N <= vis_q;
    end
  end

  assign VGA_R = pix_q.r;
  assign VGA_G = pix_q.g;
  assign VGA_B = pix_q.b;
endmodule

// File: tb/tb_vga_rect_engine.sv
// Scoreboard bench for vga_rect_engine on a shrunken raster; model honours RECT_BLINK_EN.
module tb_vga_rect_engine;
  localparam int HA = 16, HF = 2, HSW = 3, HB = 3, HT = HA + HF + HSW + HB;
  localparam int VA = 12, VF = 1, VSW = 2, VB = 2, VT = VA + VF + VSW + VB;
  localparam int NR = 4, CW = 11;
  localparam int FR = 2 * HT * VT;
`ifdef RECT_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic             CLOCK_50, nReset;
  logic [NR*CW-1:0] rect_x0, rect_x1, rect_y0, rect_y1;
  logic [NR*24-1:0] rect_color;
  logic [NR-1:0]    rect_en, rect_blink;
  logic [23:0]      bg_color;
  logic [7:0]       VGA_R, VGA_G, VGA_B;
  logic             VGA_HS, VGA_VS, VGA_CLK, VGA_BLANK_N, frame_start;

  vga_rect_engine #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .N_RECT(NR), .COORD_W(CW)
  ) dut (
    .CLOCK_50(CLOCK_50), .nReset(nReset),
    .rect_x0(rect_x0), .rect_x1(rect_x1), .rect_y0(rect_y0), .rect_y1(rect_y1),
    .rect_color(rect_color), .rect_en(rect_en), .rect_blink(rect_blink),
    .bg_color(bg_color), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_CLK(VGA_CLK),
    .VGA_BLANK_N(VGA_BLANK_N), .frame_start(frame_start)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a frame is a list of pixels; each pixel shows the first
  // shown rectangle containing it, else background, black outside the picture.
  logic [26:0] exp_q[$];
  int          m_h, m_v, m_frames, win;
  bit          m_pix, m_first, m_phase, mvis, mhs, mvs, mload;
  int          sx0[NR], sx1[NR], sy0[NR], sy1[NR];
  bit          sen[NR], sbl[NR];
  logic [23:0] scol[NR], sbg, mc;

  function automatic bit shown(input int i);
    return sen[i] && !(BLINK && sbl[i] && m_phase);
  endfunction

  always @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      m_pix = 0; m_h = 0; m_v = 0; m_first = 1; m_frames = 0; m_phase = 0;
      for (int i = 0; i < NR; i++) begin
        sx0[i] = 0; sx1[i] = 0; sy0[i] = 0; sy1[i] = 0;
        sen[i] = 0; sbl[i] = 0; scol[i] = '0;
      end
      sbg = '0;
      exp_q.delete();
    end else begin
      if (m_pix) begin
        win = -1;
        for (int i = NR - 1; i >= 0; i--)
          if (shown(i) && m_h >= sx0[i] && m_h <= sx1[i] && m_v >= sy0[i] && m_v <= sy1[i])
            win = i;
        mvis  = (m_h < HA) && (m_v < VA);
        mhs   = !(m_h >= HA + HF && m_h < HA + HF + HSW);
        mvs   = !(m_v >= VA + VF && m_v < VA + VF + VSW);
        mload = m_first || (m_h == HT - 1 && m_v == VT - 1);
        if (mload) begin
          for (int i = 0; i < NR; i++) begin
            sx0[i] = int'(rect_x0[i*CW +: CW]); sx1[i] = int'(rect_x1[i*CW +: CW]);
            sy0[i] = int'(rect_y0[i*CW +: CW]); sy1[i] = int'(rect_y1[i*CW +: CW]);
            sen[i] = rect_en[i]; sbl[i] = rect_blink[i];
            scol[i] = rect_color[i*24 +: 24];
          end
          sbg = bg_color;
          m_phase = ((m_frames / 32) % 2) == 1;
          m_frames++;
          m_first = 0;
        end
        mc = (win < 0) ? sbg : scol[win];
        if (!mvis) mc = '0;
        exp_q.push_back({mc, mhs, mvs, mvis});
        m_h++;
        if (m_h == HT) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end
      end
      m_pix = !m_pix;
    end
  end

  // Monitor: outputs trail the counter position by two pixel cycles
  logic [26:0] e;
  always @(negedge CLOCK_50) begin
    if (nReset) begin
      chk("vga_clk", 32'(VGA_CLK), 32'(m_pix));
      chk("frame_start", 32'(frame_start),
          32'(m_pix && (m_first || (m_h == HT - 1 && m_v == VT - 1))));
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        chk("pixel", 32'({VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N}), 32'(e));
      end
    end
  end

  task automatic chk_reset();
    chk("rst_r", 32'(VGA_R), 0);
    chk("rst_g", 32'(VGA_G), 0);
    chk("rst_b", 32'(VGA_B), 0);
    chk("rst_hs", 32'(VGA_HS), 1);
    chk("rst_vs", 32'(VGA_VS), 1);
    chk("rst_blank_n", 32'(VGA_BLANK_N), 0);
    chk("rst_vga_clk", 32'(VGA_CLK), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
  endtask

  task automatic set_rect(input int i, input int x0, input int x1, input int y0,
                          input int y1, input logic [23:0] c, input bit en, input bit bl);
    rect_x0[i*CW +: CW] = CW'(x0); rect_x1[i*CW +: CW] = CW'(x1);
    rect_y0[i*CW +: CW] = CW'(y0); rect_y1[i*CW +: CW] = CW'(y1);
    rect_color[i*24 +: 24] = c; rect_en[i] = en; rect_blink[i] = bl;
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic rand_inputs();
    set_rect(0, 0, $urandom_range(3, HA), 0, $urandom_range(2, VA), 24'($urandom), 1'b1, 1'b1);
    for (int i = 1; i < NR; i++)
      set_rect(i, $urandom_range(0, HT), $urandom_range(0, HT), $urandom_range(0, VT),
               $urandom_range(0, VT), 24'($urandom), 1'($urandom), 1'($urandom));
    bg_color = 24'($urandom);
  endtask

  int k;
  initial begin
    nReset = 1'b0;
    rect_x0 = '0; rect_x1 = '0; rect_y0 = '0; rect_y1 = '0;
    rect_color = '0; rect_en = '0; rect_blink = '0; bg_color = '0;
    clks(3);
    #1 chk_reset();
    clks(1);
    #2 nReset = 1'b1;
    // Single red rectangle on navy
    set_rect(0, 4, 7, 2, 5, 24'hFF0000, 1'b1, 1'b0);
    bg_color = 24'h000080;
    clks(2 * FR);
    // Overlap: green inside white, rect 0 has priority
    set_rect(0, 2, 4, 2, 4, 24'h00FF00, 1'b1, 1'b0);
    set_rect(1, 0, 8, 0, 8, 24'hFFFFFF, 1'b1, 1'b0);
    clks(FR + FR / 2);
    // Mid-frame move must not tear
    set_rect(0, 9, 14, 6, 10, 24'h00FF00, 1'b1, 1'b0);
    clks(FR);
    // Empty rectangle, then reset in the middle of a frame
    set_rect(2, 10, 9, 0, VA, 24'h123456, 1'b1, 1'b0);
    set_rect(3, 0, HA, 7, 6, 24'h654321, 1'b1, 1'b0);
    clks(FR + FR / 2);
    #3 nReset = 1'b0;
    #1 chk_reset();
    clks(3);
    #1 chk_reset();
    #2 nReset = 1'b1;
    // Randomised frames, long enough for a full blink period
    for (int f = 0; f < 66; f++) begin
      k = $urandom_range(1, FR - 1);
      clks(k);
      rand_inputs();
      clks(FR - k);
    end
    clks(8);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
